// File: rtl/dff_ar.sv
// dff_ar: WIDTH-bit D flip-flop with asynchronous active-low reset.
// This is the basic storage element for datapath registers, the program
// counter and flag bits. The output comes straight from the register, so
// there is no combinational path from in to out.
`timescale 1ns/1ps

module dff_ar #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next state is always the input: no enable and no hold mode.
    always_comb begin
        data_d = in;
    end

    // Storage. Reset takes effect at once and holds while n_rst is low,
    // independent of clk. Otherwise the register reloads on every rising edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign out = data_q;

endmodule

// File: tb/tb_dff_ar.sv
// tb_dff_ar: directed bench for dff_ar. A 1-bit default instance follows
// the timeline exactly. An 8-bit instance with a non-zero reset value shares
// the clock and reset, so reset-value and per-bit faults can be seen.
`timescale 1ns/1ps

module tb_dff_ar;

  logic       clk;
  logic       clk_en;
  logic       n_rst;
  logic       in_1;
  logic       out_1;
  logic [7:0] in_w;
  logic [7:0] out_w;

  int checks_total;
  int checks_passed;

  localparam logic [7:0] RST_W = 8'hA5;

  dff_ar u_dut_1 (
    .clk   (clk),
    .n_rst (n_rst),
    .in    (in_1),
    .out   (out_1)
  );

  dff_ar #(
    .WIDTH   (8),
    .RST_VAL (RST_W)
  ) u_dut_w (
    .clk   (clk),
    .n_rst (n_rst),
    .in    (in_w),
    .out   (out_w)
  );

  // Clock and reset block: the clock toggles every 5 ns while clk_en is high,
  // giving rising edges at 5, 15, 25 ns and so on. Clearing clk_en freezes it.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Advance to an absolute simulation time in ns.
  task automatic at_time(input int t);
    #(t - $time);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    clk_en = 1'b1;
    n_rst  = 1'b1;
    in_1   = 1'b0;
    in_w   = 8'h3C;

    // Power-up without reset: the first edge at 5 ns loads in.
    at_time(6);   check("first_edge_1", {7'd0, out_1}, 8'h00);
                  check("first_edge_w", out_w, 8'h3C);
    at_time(20);  in_w = 8'hC3;
    at_time(26);  check("update_w", out_w, 8'hC3);
    at_time(32);  in_1 = 1'b1;
    at_time(36);  check("pre_reset_1", {7'd0, out_1}, 8'h01);

    // Asynchronous assert between edges.
    at_time(50);  n_rst = 1'b0;
    at_time(51);  check("async_assert_1", {7'd0, out_1}, 8'h00);
                  check("async_assert_w", out_w, RST_W);
    at_time(56);  check("reset_hold_edge_1", {7'd0, out_1}, 8'h00);
                  check("reset_hold_edge_w", out_w, RST_W);

    // Input changes are ignored while reset is held.
    at_time(150); in_1 = 1'b1; in_w = 8'hFF;
    at_time(156); check("ignore_in_a_1", {7'd0, out_1}, 8'h00);
                  check("ignore_in_a_w", out_w, RST_W);
    at_time(250); in_1 = 1'b0; in_w = 8'h00;
    at_time(256); check("ignore_in_b_1", {7'd0, out_1}, 8'h00);
    at_time(300); in_1 = 1'b1; in_w = 8'h5A;
    at_time(306); check("ignore_in_c_1", {7'd0, out_1}, 8'h00);
                  check("ignore_in_c_w", out_w, RST_W);

    // Release between edges: reset value holds until the next rising edge.
    at_time(400); n_rst = 1'b1;
    at_time(401); check("release_hold_1", {7'd0, out_1}, 8'h00);
                  check("release_hold_w", out_w, RST_W);
    at_time(406); check("release_capture_1", {7'd0, out_1}, 8'h01);
                  check("release_capture_w", out_w, 8'h5A);

    // Normal updates with one edge of latency.
    at_time(502); in_1 = 1'b0; in_w = 8'h11;
    at_time(504); check("latency_hold_1", {7'd0, out_1}, 8'h01);
                  check("latency_hold_w", out_w, 8'h5A);
    at_time(506); check("update_fall_1", {7'd0, out_1}, 8'h00);
                  check("update_fall_w", out_w, 8'h11);
    at_time(602); in_1 = 1'b1; in_w = 8'hEE;
    at_time(606); check("update_rise_1", {7'd0, out_1}, 8'h01);
                  check("update_rise_w", out_w, 8'hEE);

    // Glitch on in between edges has no effect.
    at_time(610); in_1 = 1'b0; in_w = 8'h00;
    at_time(611); check("glitch_1", {7'd0, out_1}, 8'h01);
                  check("glitch_w", out_w, 8'hEE);
    at_time(612); in_1 = 1'b1; in_w = 8'hEE;
    at_time(616); check("post_glitch_1", {7'd0, out_1}, 8'h01);
                  check("post_glitch_w", out_w, 8'hEE);

    // Reset mid-operation with the clock stopped.
    at_time(701); clk_en = 1'b0;
    at_time(703); n_rst = 1'b0;
    at_time(704); check("stopped_reset_1", {7'd0, out_1}, 8'h00);
                  check("stopped_reset_w", out_w, RST_W);
    at_time(750); check("stopped_hold_w", out_w, RST_W);
    at_time(792); clk_en = 1'b1;
    at_time(796); check("restart_in_reset_1", {7'd0, out_1}, 8'h00);
    at_time(801); n_rst = 1'b1; in_1 = 1'b1; in_w = 8'h77;
    at_time(802); check("restart_release_1", {7'd0, out_1}, 8'h00);
                  check("restart_release_w", out_w, RST_W);
    at_time(806); check("restart_capture_1", {7'd0, out_1}, 8'h01);
                  check("restart_capture_w", out_w, 8'h77);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
